// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, opcode constants and the entry record for the ALU reservation station.
package alu_reservation_station_pkg;

    localparam int OPENUM_LEN      = 6;
    localparam int DATA_LEN        = 32;
    localparam int ROB_POS_LEN_DEF = 4;
    localparam int RS_SIZE_DEF     = 8;

    localparam logic [OPENUM_LEN-1:0] OP_ADD  = 6'd0;
    localparam logic [OPENUM_LEN-1:0] OP_SLT  = 6'd22;
    localparam logic [OPENUM_LEN-1:0] OP_SLTU = 6'd23;

    typedef struct packed {
        logic                       busy;
        logic [OPENUM_LEN-1:0]      openum;
        logic [ROB_POS_LEN_DEF-1:0] rob_pos;
        logic [DATA_LEN-1:0]        v1;
        logic [DATA_LEN-1:0]        v2;
        logic                       q1_valid;
        logic                       q2_valid;
        logic [ROB_POS_LEN_DEF-1:0] q1;
        logic [ROB_POS_LEN_DEF-1:0] q2;
    } rs_entry_t;

endpackage

// File: rtl/alu_reservation_station_select.sv
// Lowest-index priority encoder; shared by the free-slot and ready-slot searches.
module rs_select #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = i[$clog2(N)-1:0];
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until operands resolve via CDB snooping,
// then issues the lowest-index ready entry to the combinational executor each cycle.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
#(
    parameter int RS_SIZE     = RS_SIZE_DEF,
    parameter int ROB_POS_LEN = ROB_POS_LEN_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   rollback,
    input  logic                   disp_valid,
    input  logic [OPENUM_LEN-1:0]  disp_openum,
    input  logic [ROB_POS_LEN-1:0] disp_rob_pos,
    input  logic [DATA_LEN-1:0]    disp_v1,
    input  logic [DATA_LEN-1:0]    disp_v2,
    input  logic                   disp_q1_valid,
    input  logic                   disp_q2_valid,
    input  logic [ROB_POS_LEN-1:0] disp_q1,
    input  logic [ROB_POS_LEN-1:0] disp_q2,
    input  logic                   alu_cdb_valid,
    input  logic [ROB_POS_LEN-1:0] alu_cdb_rob_pos,
    input  logic [DATA_LEN-1:0]    alu_cdb_value,
    input  logic                   lsb_cdb_valid,
    input  logic [ROB_POS_LEN-1:0] lsb_cdb_rob_pos,
    input  logic [DATA_LEN-1:0]    lsb_cdb_value,
    output logic                   full,
    output logic                   exec_valid,
    output logic [OPENUM_LEN-1:0]  openum,
    output logic [DATA_LEN-1:0]    oprand1,
    output logic [DATA_LEN-1:0]    oprand2,
    output logic [ROB_POS_LEN-1:0] exec_rob_pos
);

    localparam int IDX_W = $clog2(RS_SIZE);

    rs_entry_t ent [RS_SIZE];
    rs_entry_t disp_entry;

    logic [RS_SIZE-1:0] busy_vec;
    logic [RS_SIZE-1:0] free_vec;
    logic [RS_SIZE-1:0] ready_vec;
    logic [RS_SIZE-1:0] busy_next;
    logic               free_found;
    logic               ready_found;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   ready_idx;
    logic               do_disp;

    // Resolve one operand against both CDBs; the ALU bus wins if both carry the tag.
    function automatic logic [DATA_LEN:0] snoop(input logic qv,
                                                input logic [ROB_POS_LEN-1:0] q,
                                                input logic [DATA_LEN-1:0] v);
        if (qv && alu_cdb_valid && alu_cdb_rob_pos == q) return {1'b0, alu_cdb_value};
        if (qv && lsb_cdb_valid && lsb_cdb_rob_pos == q) return {1'b0, lsb_cdb_value};
        return {qv, v};
    endfunction

    always_comb begin
        busy_vec  = '0;
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_vec[i]  = ent[i].busy;
            free_vec[i]  = ~ent[i].busy;
            ready_vec[i] = ent[i].busy & ~ent[i].q1_valid & ~ent[i].q2_valid;
        end
    end

    rs_select #(.N(RS_SIZE)) u_free_sel (
        .req   (free_vec),
        .found (free_found),
        .idx   (free_idx)
    );

    rs_select #(.N(RS_SIZE)) u_ready_sel (
        .req   (ready_vec),
        .found (ready_found),
        .idx   (ready_idx)
    );

    assign do_disp = disp_valid & ~full & free_found;

    always_comb begin
        disp_entry                        = '0;
        disp_entry.busy                   = 1'b1;
        disp_entry.openum                 = disp_openum;
        disp_entry.rob_pos                = disp_rob_pos;
        {disp_entry.q1_valid, disp_entry.v1} = snoop(disp_q1_valid, disp_q1, disp_v1);
        {disp_entry.q2_valid, disp_entry.v2} = snoop(disp_q2_valid, disp_q2, disp_v2);
        disp_entry.q1                     = disp_q1;
        disp_entry.q2                     = disp_q2;
    end

    // The allocator works from pre-issue busy, so a slot freed this cycle stays empty until next.
    always_comb begin
        busy_next = busy_vec;
        if (ready_found) busy_next[ready_idx] = 1'b0;
        if (do_disp)     busy_next[free_idx]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
            full         <= 1'b0;
            exec_valid   <= 1'b0;
            openum       <= '0;
            oprand1      <= '0;
            oprand2      <= '0;
            exec_rob_pos <= '0;
        end else if (rdy) begin
            if (rollback) begin
                for (int i = 0; i < RS_SIZE; i++) ent[i].busy <= 1'b0;
                full       <= 1'b0;
                exec_valid <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (ent[i].busy) begin
                        {ent[i].q1_valid, ent[i].v1} <= snoop(ent[i].q1_valid, ent[i].q1, ent[i].v1);
                        {ent[i].q2_valid, ent[i].v2} <= snoop(ent[i].q2_valid, ent[i].q2, ent[i].v2);
                    end
                end
                // Issue uses start-of-cycle state; a same-cycle wake-up is seen next cycle.
                if (ready_found) begin
                    exec_valid            <= 1'b1;
                    openum                <= ent[ready_idx].openum;
                    oprand1               <= ent[ready_idx].v1;
                    oprand2               <= ent[ready_idx].v2;
                    exec_rob_pos          <= ent[ready_idx].rob_pos;
                    ent[ready_idx].busy   <= 1'b0;
                end else begin
                    exec_valid <= 1'b0;
                end
                if (do_disp) ent[free_idx] <= disp_entry;
                full <= &busy_next;
            end
        end
    end

endmodule
